// File: rtl/exe_mem_reg_if.sv
// EXE -> MEM pipeline bus bundle.
// Upstream (EXE side) handshake and payload, downstream (MEM side) handshake
// and held payload, plus the committed status flags.
// slave  : the pipeline register itself.
// master : whatever drives EXE outputs and consumes MEM entries.
interface exe_mem_reg_if #(
    parameter int DW = 32
) ();
    logic          flush;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] st_val;
    logic [3:0]    dest;
    logic          wb_en;
    logic          mem_r_en;
    logic          mem_w_en;
    logic          s_en;
    logic [3:0]    sr;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_alu_result;
    logic [DW-1:0] out_st_val;
    logic [3:0]    out_dest;
    logic          out_wb_en;
    logic          out_mem_r_en;
    logic          out_mem_w_en;

    logic [3:0]    status;

    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  alu_result,
        input  st_val,
        input  dest,
        input  wb_en,
        input  mem_r_en,
        input  mem_w_en,
        input  s_en,
        input  sr,
        output out_valid,
        input  out_ready,
        output out_alu_result,
        output out_st_val,
        output out_dest,
        output out_wb_en,
        output out_mem_r_en,
        output out_mem_w_en,
        output status
    );

    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output alu_result,
        output st_val,
        output dest,
        output wb_en,
        output mem_r_en,
        output mem_w_en,
        output s_en,
        output sr,
        input  out_valid,
        output out_ready,
        input  out_alu_result,
        input  out_st_val,
        input  out_dest,
        input  out_wb_en,
        input  out_mem_r_en,
        input  out_mem_w_en,
        input  status
    );
endinterface

// File: rtl/exe_mem_reg.sv
// EXE -> MEM pipeline register with a 2-entry skid buffer and the
// architectural status register {Z,C,N,V}.
//
// Optional build macro: EXE_MEM_STALL_CNT_EN adds a 32-bit stall_cnt output
// counting upstream-blocked and downstream-blocked cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_EMPTY | nothing held; out_valid=0, in_ready=1
// ST_ONE   | main entry held and presented to MEM; skid empty, in_ready=1
// ST_FULL  | main presented, skid holds the next entry; in_ready=0
//
// Only main is ever presented to MEM; skid only fills when EXE delivers
// while MEM stalls, and it empties back into main on the next drain, which
// keeps delivery strictly in order.
module exe_mem_reg #(
    parameter int         DW       = 32,
    parameter logic [3:0] SR_RESET = 4'b0000
) (
    input  logic          clk,
    input  logic          rst,
`ifdef EXE_MEM_STALL_CNT_EN
    output logic [31:0]   stall_cnt,
`endif
    exe_mem_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DW-1:0] alu_result;
        logic [DW-1:0] st_val;
        logic [3:0]    dest;
        logic          wb_en;
        logic          mem_r_en;
        logic          mem_w_en;
    } payload_t;

    state_t   r_state;
    logic     r_out_valid;
    logic     r_in_ready;
    payload_t r_main;
    payload_t r_skid;
    logic [3:0] r_status;

    payload_t w_in_payload;
    logic     w_accept;
    logic     w_drain;

    // An instruction squashed by flush is never accepted, so it can neither
    // fill a slot nor commit flags.
    assign w_accept = bus.in_valid & r_in_ready & ~bus.flush;
    assign w_drain  = r_out_valid & bus.out_ready;

    // Pack the incoming EXE fields into one payload word.
    always_comb begin
        w_in_payload            = '0;
        w_in_payload.alu_result = bus.alu_result;
        w_in_payload.st_val     = bus.st_val;
        w_in_payload.dest       = bus.dest;
        w_in_payload.wb_en      = bus.wb_en;
        w_in_payload.mem_r_en   = bus.mem_r_en;
        w_in_payload.mem_w_en   = bus.mem_w_en;
    end

    // Occupancy FSM with registered out_valid / in_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (bus.flush) begin
            // A drain in the flush cycle still completes on the MEM side;
            // everything left behind is discarded.
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_drain) begin
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_drain && !w_accept) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Main / skid payload movement; registers hold whenever not loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main <= w_in_payload;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        r_main <= w_in_payload;
                    end else if (w_accept) begin
                        r_skid <= w_in_payload;
                    end
                end
                ST_FULL: begin
                    // On a flush+drain this moves a dead entry into main;
                    // harmless because out_valid drops in the same edge.
                    if (w_drain) begin
                        r_main <= r_skid;
                    end
                end
                default: begin
                    r_main <= r_main;
                end
            endcase
        end
    end

    // Flags commit when an S-bit instruction is accepted; a later flush of
    // the held entry does not roll them back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status <= SR_RESET;
        end else if (w_accept && bus.s_en) begin
            r_status <= bus.sr;
        end
    end

`ifdef EXE_MEM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [1:0]  w_stall_inc;

    // Upstream blocked and downstream blocked each count one per cycle.
    assign w_stall_inc = {1'b0, bus.in_valid & ~r_in_ready}
                       + {1'b0, r_out_valid & ~bus.out_ready};

    // Free-running wrap-around stall counter; flush does not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 32'(w_stall_inc);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign bus.in_ready       = r_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_alu_result = r_main.alu_result;
    assign bus.out_st_val     = r_main.st_val;
    assign bus.out_dest       = r_main.dest;
    // Controls are qualified so a stale entry can never trigger MEM/WB.
    assign bus.out_wb_en      = r_main.wb_en    & r_out_valid;
    assign bus.out_mem_r_en   = r_main.mem_r_en & r_out_valid;
    assign bus.out_mem_w_en   = r_main.mem_w_en & r_out_valid;
    assign bus.status         = r_status;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Scoreboard bench for exe_mem_reg: the driver pushes each instruction it
// expects to be accepted; a negedge monitor pops on every MEM drain and also
// checks handshake, status and (optionally) stall_cnt against a simple
// occupancy model.
module tb_exe_mem_reg;

    localparam logic [3:0] TB_SR_RESET = 4'b1010;

    typedef struct {
        logic [31:0] a;
        logic [31:0] st;
        logic [3:0]  d;
        logic        wb;
        logic        mr;
        logic        mw;
    } ent_t;

    logic clk;
    logic rst;

    exe_mem_reg_if #(.DW(32)) bus ();

`ifdef EXE_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt;
    exe_mem_reg #(.DW(32), .SR_RESET(TB_SR_RESET)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_cnt (stall_cnt),
        .bus       (bus)
    );
`else
    exe_mem_reg #(.DW(32), .SR_RESET(TB_SR_RESET)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t exp_q[$];
    int   model_occ = 0;
    logic [3:0]  exp_status = TB_SR_RESET;
    logic [31:0] exp_stall = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus; push the entry if the model says it lands.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] st,
                         input logic [3:0] d, input logic [2:0] ctl, input logic s,
                         input logic [3:0] srv, input logic ordy, input logic fl);
        ent_t e;
        @(posedge clk);
        #1;
        bus.in_valid   = v;
        bus.alu_result = a;
        bus.st_val     = st;
        bus.dest       = d;
        bus.wb_en      = ctl[2];
        bus.mem_r_en   = ctl[1];
        bus.mem_w_en   = ctl[0];
        bus.s_en       = s;
        bus.sr         = srv;
        bus.out_ready  = ordy;
        bus.flush      = fl;
        if (rst && v && (model_occ < 2) && !fl) begin
            e.a  = a;
            e.st = st;
            e.d  = d;
            e.wb = ctl[2];
            e.mr = ctl[1];
            e.mw = ctl[0];
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b0, 4'h0, ordy, 1'b0);
    endtask

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        ent_t e;
        logic acc;
        logic drn;
        if (!rst) begin
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
            chk("rst_status", 32'(bus.status), 32'(TB_SR_RESET));
            chk("rst_out_alu_result", bus.out_alu_result, 32'd0);
`ifdef EXE_MEM_STALL_CNT_EN
            chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
            exp_q.delete();
            model_occ  = 0;
            exp_status = TB_SR_RESET;
            exp_stall  = 0;
        end else begin
            chk("out_valid", 32'(bus.out_valid), 32'(model_occ > 0));
            chk("in_ready", 32'(bus.in_ready), 32'(model_occ < 2));
            chk("status", 32'(bus.status), 32'(exp_status));
`ifdef EXE_MEM_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, exp_stall);
`endif
            if (model_occ == 0)
                chk("ctl_gated", 32'({bus.out_wb_en, bus.out_mem_r_en, bus.out_mem_w_en}), 32'd0);

            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_drain", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_alu_result", bus.out_alu_result, e.a);
                    chk("out_st_val", bus.out_st_val, e.st);
                    chk("out_dest", 32'(bus.out_dest), 32'(e.d));
                    chk("out_ctl", 32'({bus.out_wb_en, bus.out_mem_r_en, bus.out_mem_w_en}),
                        32'({e.wb, e.mr, e.mw}));
                end
            end

            drn = (model_occ > 0) && bus.out_ready;
            acc = bus.in_valid && (model_occ < 2) && !bus.flush;
            exp_stall = exp_stall + 32'(bus.in_valid && (model_occ == 2))
                                  + 32'((model_occ > 0) && !bus.out_ready);
            if (acc && bus.s_en)
                exp_status = bus.sr;
            if (bus.flush) begin
                exp_q.delete();
                model_occ = 0;
            end else begin
                model_occ = model_occ - int'(drn) + int'(acc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst            = 1'b0;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.alu_result = '0;
        bus.st_val     = '0;
        bus.dest       = '0;
        bus.wb_en      = 1'b0;
        bus.mem_r_en   = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.s_en       = 1'b0;
        bus.sr         = '0;
        bus.out_ready  = 1'b0;

        // Reset held with live input: nothing may be captured.
        repeat (3) drive(1'b1, 32'hDEAD_BEEF, 32'h1, 4'hF, 3'b111, 1'b1, 4'h5, 1'b1, 1'b0);
        idle(1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // First transaction.
        drive(1'b1, 32'h5, 32'h0, 4'd3, 3'b100, 1'b0, 4'h0, 1'b1, 1'b0);
        idle(1'b1);

        // Backpressure: A, B fill both slots; C refused while full.
        drive(1'b1, 32'h11, 32'hA1, 4'd1, 3'b010, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 32'hA2, 4'd2, 3'b001, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h33, 32'hA3, 4'd3, 3'b100, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h33, 32'hA3, 4'd3, 3'b100, 1'b0, 4'h0, 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        // Streaming 1..8.
        for (int i = 1; i <= 8; i++)
            drive(1'b1, 32'(i), 32'(i * 16), 4'(i), 3'b100, 1'b0, 4'h0, 1'b1, 1'b0);
        repeat (2) idle(1'b1);

        // Flags commit only with s_en.
        drive(1'b1, 32'h40, 32'h0, 4'd4, 3'b100, 1'b1, 4'b1100, 1'b1, 1'b0);
        drive(1'b1, 32'h41, 32'h0, 4'd5, 3'b100, 1'b0, 4'b0011, 1'b1, 1'b0);
        repeat (2) idle(1'b1);

        // Fill, sit full three cycles with input pending, then flush.
        drive(1'b1, 32'h50, 32'h5, 4'd6, 3'b001, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h51, 32'h6, 4'd7, 3'b001, 1'b0, 4'h0, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 32'h52, 32'h7, 4'd8, 3'b001, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h53, 32'h8, 4'd9, 3'b001, 1'b1, 4'b0001, 1'b0, 1'b1);
        repeat (2) idle(1'b1);

        // Flush coinciding with a drain: the drained entry is still delivered.
        drive(1'b1, 32'h60, 32'h0, 4'd1, 3'b100, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h61, 32'h0, 4'd2, 3'b100, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h62, 32'h0, 4'd3, 3'b100, 1'b1, 4'b0110, 1'b1, 1'b1);
        repeat (2) idle(1'b1);

        // Asynchronous reset in the middle of a full cycle.
        drive(1'b1, 32'h70, 32'h0, 4'd1, 3'b111, 1'b1, 4'b0101, 1'b0, 1'b0);
        drive(1'b1, 32'h71, 32'h0, 4'd2, 3'b111, 1'b0, 4'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_status", 32'(bus.status), 32'(TB_SR_RESET));
        chk("midrst_out_wb_en", 32'(bus.out_wb_en), 32'd0);
        idle(1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 9) < 7), $urandom, $urandom, 4'($urandom_range(0, 15)),
                  3'($urandom), 1'($urandom), 4'($urandom), 1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 19) == 0));
        end

        repeat (4) idle(1'b1);
        chk("leftover_entries", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exe_mem_reg.md
Name: exe_mem_reg

Overview:
- EXE→MEM pipeline boundary directly downstream of the ALU.
- Captures ALU result, store data, destination and memory/writeback controls behind a valid/ready handshake with a 2-entry skid buffer.
- Owns the architectural status register: flags {Z,C,N,V} from the ALU are committed when an S-bit instruction is accepted.
- Provides synchronous flush for branch/mispredict squash.

Parameters:
- DW, 32, data width of alu_result / st_val paths.
- SR_RESET, 4'b0000, status register value after reset, ordered {Z,C,N,V}.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous squash of all held and incoming entries.
- in_valid  in  1  EXE has an instruction this cycle.
- in_ready  out  1  block can accept; registered, equals !skid_valid.
- alu_result  in  DW  ALU result.
- st_val  in  DW  store data (Rm value).
- dest  in  4  destination register index.
- wb_en  in  1  writeback enable.
- mem_r_en  in  1  load.
- mem_w_en  in  1  store.
- s_en  in  1  instruction updates flags.
- sr  in  4  ALU flags {Z,C,N,V}.
- out_valid  out  1  MEM entry valid.
- out_ready  in  1  MEM consumes entry.
- out_alu_result  out  DW  held result.
- out_st_val  out  DW  held store data.
- out_dest  out  4  held destination.
- out_wb_en, out_mem_r_en, out_mem_w_en  out  1 each  held controls; forced 0 whenever out_valid=0.
- status  out  4  committed flags {Z,C,N,V}.

Behaviour:
- Reset (rst=0, async):
  - main_valid=0, skid_valid=0, in_ready=1, out_valid=0.
  - All payload outputs = 0; status = SR_RESET.
  - Inputs are ignored while reset is asserted.
- Handshake events:
  - accept = in_valid & in_ready & !flush.
  - drain = out_valid & out_ready.
- States by (main_valid, skid_valid):
  - EMPTY (0,0):
    - accept → ONE; entry loads main.
    - Latency: accept at edge N → out_valid=1 after edge N.
  - ONE (1,0):
    - accept & drain → ONE; main loads new entry.
    - accept & !drain → FULL; entry loads skid, in_ready=0 next cycle.
    - drain & !accept → EMPTY.
    - Neither → hold.
  - FULL (1,1):
    - in_ready=0, so no accept.
    - drain → ONE; skid moves to main, in_ready=1 next cycle.
    - Otherwise hold.
- Order is strictly FIFO.
- Payload registers hold their last value when not loaded.
- flush=1:
  - Next state EMPTY regardless of accept/drain.
  - An entry presented in the same cycle is dropped.
  - A same-cycle drain still counts as consumed by MEM.
- Status register:
  - On accept with s_en=1, status ← sr at that edge.
  - s_en=0 or no accept → status holds.
  - Flush cycle → no status update.
  - Status is not rolled back when held entries are flushed.
- Control gating: out_wb_en/out_mem_r_en/out_mem_w_en = stored bit & out_valid.
- Mid-operation reset: everything returns to reset values immediately. No partial entry survives.

Optional Feature:
- Macro: EXE_MEM_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0].
  - Increments every cycle with in_valid=1 and in_ready=0, and every cycle with out_valid=1 and out_ready=0.
  - Increments by 2 when both hold in one cycle.
  - Wraps at 2^32-1 → 0.
  - Reset to 0; unaffected by flush.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: rst=0 with in_valid=1 → out_valid=0, in_ready=1, status=SR_RESET. Release rst, then accept alu_result=32'h0000_0005, dest=3, wb_en=1 → next cycle out_valid=1, out_alu_result=5, out_dest=3, out_wb_en=1.
- Backpressure: out_ready=0; accept A=32'h11 then B=32'h22 → in_ready=0 after B. Raise out_ready → outputs 32'h11 then 32'h22 on consecutive cycles, in_ready=1 after first drain; C=32'h33 is not taken while in_ready=0.
- Streaming: in_valid=1, out_ready=1, values 1..8 → eight consecutive out_valid cycles carrying 1..8, in_ready constantly 1.
- Flags: accept with s_en=1, sr=4'b1100 → status=4'b1100 next cycle. Accept with s_en=0, sr=4'b0011 → status stays 4'b1100.
- Flush: FULL state, then flush=1 with in_valid=1, s_en=1, sr=4'b0001 → next cycle out_valid=0, in_ready=1, status unchanged, out_mem_w_en=0.
- EXE_MEM_STALL_CNT_EN: 3 cycles in FULL with in_valid=1 and out_ready=0 → stall_cnt=6.
